load_hazard_unit: RTL and testbench
===================================

LOAD_HAZARD_UNIT -- requirements
Module: load_hazard_unit

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT SHALL default to 255 and be the maximum number of memory-wait cycles before abort (range 1..255).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 clr  in  1  synchronous active-high reset.
REQ-005 id_inst  in  32  instruction held in the IF/ID register.
REQ-006 id_valid  in  1  id_inst is a real instruction, not a bubble.
REQ-007 ex_m2reg  in  1  instruction in EX is a load (lw).
REQ-008 ex_rn  in  5  destination register of the EX instruction.
REQ-009 mem_req  in  1  MEM stage is accessing data memory this cycle.
REQ-010 mem_ready  in  1  data memory completes the access this cycle.
REQ-011 loaddepend  out  1  hold PC and IF/ID.
REQ-012 bubble  out  1  load a nop into ID/EX.
REQ-013 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-014 mem_timeout  out  1  one-cycle pulse: memory wait aborted.
REQ-015 stall_cnt  out  32  stall-cycle counter (see Configuration).

Function
REQ-016 Decode SHALL take rs=id_inst[25:21], rt=id_inst[20:16], op=id_inst[31:26], funct=id_inst[5:0].
REQ-017 uses_rs SHALL be 1 except for j (000010), jal (000011), lui (001111), and R-type funct sll/srl/sra (000000/000010/000011).
REQ-018 uses_rt SHALL be 1 for R-type (op 000000), sw (101011), beq (000100) and bne (000101); otherwise 0.
REQ-019 hazard SHALL = id_valid & ex_m2reg & (ex_rn!=0) & ((uses_rs & rs==ex_rn) | (uses_rt & rt==ex_rn)).
REQ-020 mem_stall SHALL = mem_req & ~mem_ready.
REQ-021 The FSM SHALL have exactly three states: RUN, MWAIT and TOUT, with reset state RUN.
REQ-022 In RUN: freeze=mem_stall; bubble=hazard & ~mem_stall; loaddepend=hazard | mem_stall.
REQ-023 RUN SHALL go to MWAIT when mem_stall=1 and otherwise stay in RUN.
REQ-024 In MWAIT: loaddepend=freeze=~mem_ready and bubble=0; mem_ready=1 releases in the same cycle and returns to RUN.
REQ-025 The wait counter (8 bits) SHALL clear on entering MWAIT and increment for each MWAIT cycle with mem_ready=0.
REQ-026 When the wait counter reaches TIMEOUT with mem_ready=0, the FSM SHALL go to TOUT.
REQ-027 TOUT SHALL last one cycle with mem_timeout=1, loaddepend=freeze=1 and bubble=0, then go to RUN.
REQ-028 A load-use hazard coinciding with a memory stall SHALL be re-evaluated only after release; bubble is never asserted together with freeze.
REQ-029 A back-to-back load-use with the same register SHALL give exactly one bubble cycle, because the bubble clears ex_m2reg.
REQ-030 All outputs except mem_timeout and stall_cnt SHALL be combinational from state and inputs (zero latency).

Reset
REQ-031 clr=1 at a clock edge SHALL force state RUN, wait counter 0, stall_cnt 0 and mem_timeout 0.
REQ-032 clr asserted mid-MWAIT SHALL abort the wait without a mem_timeout pulse.

Configuration
REQ-033 With STALL_CNT_EN defined, stall_cnt SHALL increment (saturating at 0xFFFFFFFF) on each cycle with loaddepend=1.
REQ-034 Without STALL_CNT_EN, stall_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Structure
REQ-035 The shared package cpu_pkg SHALL hold the opcode/funct constants and the state enum (RUN/MWAIT/TOUT).
REQ-036 The rs/rt usage decode SHALL be one sub-module, reg_use_decode (inputs id_inst; outputs uses_rs, uses_rt).

Verification
REQ-037 Load-use: ex_m2reg=1, ex_rn=8, id_inst=add $9,$8,$10 -> loaddepend=bubble=1 for one cycle, freeze=0.
REQ-038 $zero and unused fields: ex_rn=0, or id_inst=lui $8 with ex_rn=8 -> loaddepend=0.
REQ-039 Memory wait: mem_req=1 and mem_ready low for 3 cycles -> loaddepend=freeze=1 for 3 cycles, released in the cycle mem_ready=1.
REQ-040 Timeout: TIMEOUT=4 and mem_ready held 0 -> mem_timeout pulses once 5 cycles after the stall starts, then state RUN.
REQ-041 Simultaneous events: hazard together with mem_stall -> freeze=1, bubble=0; after mem_ready, bubble=1 for one cycle.
REQ-042 Counter: with STALL_CNT_EN, run scenarios REQ-037 and REQ-039 -> stall_cnt=4; clr mid-wait -> stall_cnt=0 and no mem_timeout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants and hazard-FSM state encoding for the pipeline control blocks.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        TOUT  = 2'd2
    } state_t;

    // Shift-by-immediate R-type ops take their source from rt; the rs field is unused.
    function automatic logic is_shamt_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Decodes which source register fields (rs, rt) the ID-stage instruction actually reads.
// Purely combinational, zero latency; no flow control.
module reg_use_decode
    import cpu_pkg::*;
(
    input  logic [31:0] id_inst,
    output logic        uses_rs,
    output logic        uses_rt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op    = id_inst[31:26];
    assign funct = id_inst[5:0];
    assign unused_fields = ^id_inst[25:6];

    assign uses_rs = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI) ||
                       ((op == OP_RTYPE) && is_shamt_shift(funct)));

    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

endmodule

// File: rtl/load_hazard_unit.sv
// Load-use hazard / memory-wait stall control; stall outputs are zero-latency, mem_timeout is registered.
// Memory stall freezes the pipe and masks the bubble; optional stall counter under STALL_CNT_EN.
module load_hazard_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        loaddepend,
    output logic        bubble,
    output logic        freeze,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic       uses_rs;
    logic       uses_rt;
    logic       hazard;
    logic       mem_stall;
    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_timeout_q, mem_timeout_d;

    reg_use_decode u_decode (
        .id_inst (id_inst),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    assign hazard = id_valid && ex_m2reg && (ex_rn != 5'd0) &&
                    ((uses_rs && (id_inst[25:21] == ex_rn)) ||
                     (uses_rt && (id_inst[20:16] == ex_rn)));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_timeout_d = 1'b0;
        loaddepend    = 1'b0;
        bubble        = 1'b0;
        freeze        = 1'b0;
        case (state_q)
            RUN: begin
                // A hazard seen during a memory stall is re-evaluated once the stall releases.
                freeze     = mem_stall;
                bubble     = hazard && !mem_stall;
                loaddepend = hazard || mem_stall;
                if (mem_stall) begin
                    state_d = MWAIT;
                    wait_d  = 8'd0;
                end
            end
            MWAIT: begin
                freeze     = !mem_ready;
                loaddepend = !mem_ready;
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) begin
                        state_d       = TOUT;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            TOUT: begin
                freeze     = 1'b1;
                loaddepend = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= RUN;
            wait_q        <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt_q <= 32'd0;
        end else if (loaddepend && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_load_hazard_unit.sv
// Self-checking bench for load_hazard_unit (TIMEOUT=4); expectations queued per driven cycle.
module tb_load_hazard_unit;

    logic        clk;
    logic        clr;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_m2reg;
    logic [4:0]  ex_rn;
    logic        mem_req;
    logic        mem_ready;
    logic        loaddepend;
    logic        bubble;
    logic        freeze;
    logic        mem_timeout;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {loaddepend, bubble, freeze, mem_timeout}
    logic [3:0] exp_q[$];

    typedef struct packed {
        logic [31:0] inst;
        logic        vld;
        logic        m2reg;
        logic [4:0]  rn;
        logic        req;
        logic        rdy;
        logic        rst;
        logic [3:0]  exp;
    } vec_t;

    localparam logic [31:0] ADD_9_8_10 = {6'b000000, 5'd8, 5'd10, 5'd9, 5'd0, 6'b100000};
    localparam logic [31:0] ADD_9_0_10 = {6'b000000, 5'd0, 5'd10, 5'd9, 5'd0, 6'b100000};
    localparam logic [31:0] LUI_8      = {6'b001111, 5'd0, 5'd8, 16'h1234};
    localparam logic [31:0] SLL_9_8    = {6'b000000, 5'd0, 5'd8, 5'd9, 5'd2, 6'b000000};
    localparam logic [31:0] SLL_RS8    = {6'b000000, 5'd8, 5'd3, 5'd9, 5'd2, 6'b000000};
    localparam logic [31:0] SRA_RS8    = {6'b000000, 5'd8, 5'd3, 5'd9, 5'd2, 6'b000011};
    localparam logic [31:0] LW_8_5     = {6'b100011, 5'd5, 5'd8, 16'h0000};
    localparam logic [31:0] SW_8_5     = {6'b101011, 5'd5, 5'd8, 16'h0004};
    localparam logic [31:0] BEQ_3_8    = {6'b000100, 5'd3, 5'd8, 16'h0001};
    localparam logic [31:0] BNE_8_3    = {6'b000101, 5'd8, 5'd3, 16'h0001};
    localparam logic [31:0] J_8_8      = {6'b000010, 5'd8, 5'd8, 16'h0000};
    localparam logic [31:0] JAL_8_8    = {6'b000011, 5'd8, 5'd8, 16'h0000};
    localparam logic [31:0] ADDI_9_8   = {6'b001000, 5'd8, 5'd9, 16'h0005};
    localparam logic [31:0] ADDI_8_5   = {6'b001000, 5'd5, 5'd8, 16'h0005};

`ifdef STALL_CNT_EN
    localparam logic [31:0] CNT_AFTER_LU_MW = 32'd4;
`else
    localparam logic [31:0] CNT_AFTER_LU_MW = 32'd0;
`endif

    load_hazard_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .ex_m2reg    (ex_m2reg),
        .ex_rn       (ex_rn),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .loaddepend  (loaddepend),
        .bubble      (bubble),
        .freeze      (freeze),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        id_inst   = v.inst;
        id_valid  = v.vld;
        ex_m2reg  = v.m2reg;
        ex_rn     = v.rn;
        mem_req   = v.req;
        mem_ready = v.rdy;
        clr       = v.rst;
        exp_q.push_back(v.exp);
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt got=%0d expected=0", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        // The bubble turns EX into a nop, so the same instruction no longer stalls.
        v.push_back('{ADD_9_8_10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL load_use[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0000});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mem_wait[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_counter();
        n_cmp++;
        if (stall_cnt !== CNT_AFTER_LU_MW) begin
            n_err++;
            $display("FAIL stall_cnt got=%0d expected=%0d", stall_cnt, CNT_AFTER_LU_MW);
        end
    endtask

    task automatic test_decode();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{ADD_9_0_10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{LUI_8,      1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{SLL_9_8,    1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{SLL_RS8,    1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{SRA_RS8,    1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{LW_8_5,     1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{SW_8_5,     1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{BEQ_3_8,    1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{BNE_8_3,    1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{J_8_8,      1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{JAL_8_8,    1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{ADDI_9_8,   1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{ADDI_8_5,   1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{ADD_9_8_10, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL decode[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000});
        for (int i = 0; i < 5; i++)
            v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1011});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL timeout[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 4'b0000});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 4'b1100});
        v.push_back('{ADD_9_8_10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL simultaneous[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clr_midwait();
        vec_t v[$];
        logic [3:0] got, e;
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1010});
        v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 4'b1010});
        for (int i = 0; i < 6; i++)
            v.push_back('{32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            got = {loaddepend, bubble, freeze, mem_timeout};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL clr_midwait[%0d] got=%b expected=%b", i, got, e);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL clr_stall_cnt got=%0d expected=0", stall_cnt);
        end
    endtask

    initial begin
        clr       = 1'b1;
        id_inst   = 32'd0;
        id_valid  = 1'b0;
        ex_m2reg  = 1'b0;
        ex_rn     = 5'd0;
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_counter();
        test_decode();
        test_timeout();
        test_simultaneous();
        test_clr_midwait();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
